intro_sequencer: RTL and testbench
==================================

Name: intro_sequencer

Overview:
- Frame-rate animation controller for the title screen.
- Detects each vertical-sync rising edge from the VGA timing generator and steps the title-intro sequence: hold, logo slide-out, head drop-in, done.
- Drives the hoffset of the logo layer transformer and the voffset of the head layer transformer.
- Runs entirely in the CLK100MHZ domain; vsync comes from the divided pixel clock and is synchronised internally.

Parameters:
- HOLD_FRAMES, 45: frames spent in HOLD before the slide starts (0 = start directly in SLIDE).
- SLIDE_STEP, 5: logo hoffset decrement per frame (positive).
- SLIDE_END, -600: final logo hoffset (signed 12-bit).
- HEAD_START, -170: initial head voffset (signed 12-bit).
- DROP_STEP, 10: head voffset increment per frame (positive).

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  synchronous active-low reset.
- vsync  in  1  VGA vsync, asynchronous to CLK100MHZ.
- restart  in  1  one-cycle pulse; restarts the sequence from HOLD.
- skip  in  1  level; forces the final (DONE) pose.
- frame_tick  out  1  one-cycle pulse per detected vsync rising edge.
- logo_hoffset  out  12 signed  logo layer horizontal offset.
- head_voffset  out  12 signed  head layer vertical offset.
- state  out  2  00 HOLD, 01 SLIDE, 10 DROP, 11 DONE.
- done  out  1  high while state == DONE.

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge) sets all of the following:
  - synchroniser flops = 0, frame_tick = 0, hold counter = HOLD_FRAMES.
  - logo_hoffset = 0, head_voffset = HEAD_START.
  - state = HOLD (SLIDE if HOLD_FRAMES == 0), done = 0.
- Edge detect: vsync -> s1 -> s2 -> s3 flops; frame_tick is registered as s2 & ~s3.
  - If vsync is first sampled high at edge E0, frame_tick is high for exactly the cycle after E2.
  - The FSM acts at E3.
  - Exactly one tick per vsync high period, regardless of vsync width (at least 1 CLK100MHZ cycle).
- Priority per edge: reset > restart > skip > frame_tick.
- restart: same values as reset, except the synchroniser flops are preserved.
- skip: next edge gives logo_hoffset = SLIDE_END, head_voffset = 0, state = DONE, done = 1. Has no effect if already in DONE.
- FSM actions on a frame_tick cycle only; otherwise all registers hold.
  - HOLD: counter decrements. When counter == 1, next state is SLIDE. Offsets unchanged.
  - SLIDE: logo_hoffset <= max(logo_hoffset - SLIDE_STEP, SLIDE_END), a clamp so there is no overshoot. When the new value equals SLIDE_END, next state is DROP.
  - DROP: head_voffset <= min(head_voffset + DROP_STEP, 0), a clamp. When the new value is 0, next state is DONE and done = 1 on the same edge.
  - DONE: holds all values indefinitely; frame_tick continues to pulse.
- Only one offset changes per tick. The final value of a stage and the first step of the next stage land on consecutive ticks.
- Arithmetic: 13-bit signed intermediate for the clamp compare; outputs are 12-bit signed.
- With defaults, DONE is reached on tick 182: 45 HOLD + 120 SLIDE + 17 DROP.
- Outputs are registered. The transformer consumes them combinationally; updates land during vertical blanking.

Test Plan:
- Reset then 200 vsync pulses (defaults):
  - state = SLIDE after tick 45; logo_hoffset = -5 after tick 46 and -600 after tick 165.
  - head_voffset = -160 after tick 166 and 0 after tick 182; done = 1 from tick 182 on.
  - Values stay constant through ticks 183-200.
- vsync held high for 100 cycles, then low, then high 1 cycle: exactly two frame_tick pulses.
  - Each pulse lands 3 edges after vsync is first sampled high.
- SLIDE_STEP = 7, SLIDE_END = -600: logo_hoffset goes -595 -> -600 (clamped, never -602), then state = DROP.
- skip asserted during SLIDE (logo_hoffset = -300): next edge gives -600 / 0 / DONE / done = 1.
  - skip and frame_tick in the same cycle: the skip result is applied and no extra step occurs.
- restart pulse in DROP, same cycle as a frame_tick: next edge gives logo_hoffset = 0, head_voffset = -170, state = HOLD, counter = 45.
  - The tick is ignored.
- CPU_RESETN low for 1 cycle mid-SLIDE (logo_hoffset = -250): full reset values.
  - A vsync pulse arriving 1 cycle after reset release is still detected (one tick).

Source files
------------

// File: rtl/intro_sequencer_if.sv
// Control and pose signals between the title-screen sequencer and its surroundings.
// The master side drives vsync/restart/skip; the slave side is the sequencer.
interface intro_sequencer_if;
  logic               vsync;
  logic               restart;
  logic               skip;
  logic               frame_tick;
  logic signed [11:0] logo_hoffset;
  logic signed [11:0] head_voffset;
  logic        [1:0]  state;
  logic               done;

  modport master (
    output vsync, restart, skip,
    input  frame_tick, logo_hoffset, head_voffset, state, done
  );

  modport slave (
    input  vsync, restart, skip,
    output frame_tick, logo_hoffset, head_voffset, state, done
  );
endinterface

// File: rtl/intro_sequencer.sv
// Title-intro animation controller: one step per vsync rising edge through
// HOLD -> logo SLIDE -> head DROP -> DONE, driving the layer offsets.
module intro_sequencer #(
  parameter int HOLD_FRAMES = 45,
  parameter int SLIDE_STEP  = 5,
  parameter int SLIDE_END   = -600,
  parameter int HEAD_START  = -170,
  parameter int DROP_STEP   = 10
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  intro_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_SLIDE = 2'b01,
    S_DROP  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam state_t             START_STATE = (HOLD_FRAMES == 0) ? S_SLIDE : S_HOLD;
  localparam logic        [15:0] HOLD_INIT   = 16'(HOLD_FRAMES);
  localparam logic signed [11:0] END12       = 12'(SLIDE_END);
  localparam logic signed [12:0] END13       = 13'(SLIDE_END);
  localparam logic signed [11:0] HEAD12      = 12'(HEAD_START);
  localparam logic signed [12:0] SSTEP13     = 13'(SLIDE_STEP);
  localparam logic signed [12:0] DSTEP13     = 13'(DROP_STEP);

  // Step left by SLIDE_STEP but never past SLIDE_END.
  function automatic logic signed [11:0] slide_clamp(input logic signed [11:0] cur);
    logic signed [12:0] nxt;
    nxt = $signed({cur[11], cur}) - SSTEP13;
    slide_clamp = (nxt <= END13) ? END12 : nxt[11:0];
  endfunction

  // Step down by DROP_STEP but never past zero.
  function automatic logic signed [11:0] drop_clamp(input logic signed [11:0] cur);
    logic signed [12:0] nxt;
    nxt = $signed({cur[11], cur}) + DSTEP13;
    drop_clamp = (nxt >= 13'sd0) ? 12'sd0 : nxt[11:0];
  endfunction

  logic               sync_p0, sync_p1, sync_p2;
  logic               tick_q;
  state_t             state_q, state_d;
  logic signed [11:0] logo_q, logo_d, slide_v;
  logic signed [11:0] head_q, head_d, drop_v;
  logic        [15:0] cnt_q, cnt_d;

  // vsync synchroniser / edge detect, then the pose registers.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= START_STATE;
      logo_q  <= 12'sd0;
      head_q  <= HEAD12;
      cnt_q   <= HOLD_INIT;
    end else begin
      sync_p0 <= bus.vsync;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      tick_q  <= bus.restart ? 1'b0 : (sync_p1 & ~sync_p2);
      state_q <= state_d;
      logo_q  <= logo_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    logo_d  = logo_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    slide_v = slide_clamp(logo_q);
    drop_v  = drop_clamp(head_q);
    if (bus.restart) begin
      state_d = START_STATE;
      logo_d  = 12'sd0;
      head_d  = HEAD12;
      cnt_d   = HOLD_INIT;
    end else if (bus.skip && state_q != S_DONE) begin
      state_d = S_DONE;
      logo_d  = END12;
      head_d  = 12'sd0;
    end else if (tick_q) begin
      unique case (state_q)
        S_HOLD: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_SLIDE;
        end
        S_SLIDE: begin
          logo_d = slide_v;
          if (slide_v == END12) state_d = S_DROP;
        end
        S_DROP: begin
          head_d = drop_v;
          if (drop_v == 12'sd0) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.frame_tick   = tick_q;
    bus.logo_hoffset = logo_q;
    bus.head_voffset = head_q;
    bus.state        = state_q;
    bus.done         = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_intro_sequencer.sv
// Bench for intro_sequencer: random vsync pulse widths checked every cycle against
// a closed-form pose model, plus directed restart/skip/reset scenarios.
module tb_intro_sequencer;
  localparam int H  = 45;
  localparam int SS = 5;
  localparam int SE = -600;
  localparam int HS = -170;
  localparam int DS = 10;
  localparam int S_TICKS = (-SE + SS - 1) / SS;
  localparam int D_TICKS = (-HS + DS - 1) / DS;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic chk_en = 1'b0;

  intro_sequencer_if ifa ();
  intro_sequencer_if ifb ();

  intro_sequencer dut_a (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .bus        (ifa.slave)
  );

  intro_sequencer #(.HOLD_FRAMES(2), .SLIDE_STEP(7)) dut_b (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .bus        (ifb.slave)
  );

  assign ifb.vsync   = ifa.vsync;
  assign ifb.restart = 1'b0;
  assign ifb.skip    = 1'b0;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pose after n applied ticks, straight from the stage lengths.
  function automatic int f_state(input int n);
    int k;
    if (n < H) return 0;
    k = n - H;
    if (k < S_TICKS) return 1;
    if (k - S_TICKS < D_TICKS) return 2;
    return 3;
  endfunction

  function automatic int f_logo(input int n);
    int v;
    if (n < H) return 0;
    v = -(n - H) * SS;
    return (v < SE) ? SE : v;
  endfunction

  function automatic int f_head(input int n);
    int k, v;
    k = n - H - S_TICKS;
    if (k <= 0) return HS;
    v = HS + k * DS;
    return (v > 0) ? 0 : v;
  endfunction

  // Reference: a tick follows two samples after vsync is seen rising; n counts applied ticks.
  logic [2:0] hist = 3'b000;
  logic       m_tick = 1'b0;
  logic       m_forced = 1'b0;
  int         m_n = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      hist     <= 3'b000;
      m_tick   <= 1'b0;
      m_n      <= 0;
      m_forced <= 1'b0;
    end else begin
      hist <= {hist[1:0], ifa.vsync};
      if (ifa.restart) begin
        m_tick   <= 1'b0;
        m_n      <= 0;
        m_forced <= 1'b0;
      end else begin
        m_tick <= hist[1] & ~hist[2];
        if (ifa.skip && !(m_forced || f_state(m_n) == 3)) m_forced <= 1'b1;
        else if (m_tick) m_n <= m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick",  int'(ifa.frame_tick), int'(m_tick));
      chk("state", int'(ifa.state), m_forced ? 3 : f_state(m_n));
      chk("logo",  int'($signed(ifa.logo_hoffset)), m_forced ? SE : f_logo(m_n));
      chk("head",  int'($signed(ifa.head_voffset)), m_forced ? 0 : f_head(m_n));
      chk("done",  int'(ifa.done), (m_forced || f_state(m_n) == 3) ? 1 : 0);
      chk("b_floor", int'($signed(ifb.logo_hoffset) < -600), 0);
    end
  end

  task automatic pulse(input int w, input int l);
    ifa.vsync = 1'b1;
    repeat (w) @(negedge clk);
    ifa.vsync = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse($urandom_range(1, 4), $urandom_range(4, 7));
  endtask

  // One-cycle vsync, then return on the negedge where frame_tick is high.
  task automatic wait_tick(input string tag, output bit found);
    found = 1'b0;
    ifa.vsync = 1'b1;
    @(negedge clk);
    ifa.vsync = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(tag, 0, 1);
  endtask

  task automatic restart_pulse();
    ifa.restart = 1'b1;
    @(negedge clk);
    ifa.restart = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt, first_i;
    bit found;
    ifa.vsync = 1'b0;
    ifa.restart = 1'b0;
    ifa.skip = 1'b0;

    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_logo",  int'($signed(ifa.logo_hoffset)), 0);
    chk("rst_head",  int'($signed(ifa.head_voffset)), -170);
    chk("rst_state", int'(ifa.state), 0);
    chk("rst_done",  int'(ifa.done), 0);
    chk("rst_tick",  int'(ifa.frame_tick), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int p = 1; p <= 200; p++) begin
      pulse($urandom_range(1, 4), $urandom_range(4, 7));
      case (p)
        45:  chk("t45_state", int'(ifa.state), 1);
        46:  chk("t46_logo", int'($signed(ifa.logo_hoffset)), -5);
        87: begin
          chk("b_logo_595", int'($signed(ifb.logo_hoffset)), -595);
          chk("b_state_slide", int'(ifb.state), 1);
        end
        88: begin
          chk("b_logo_600", int'($signed(ifb.logo_hoffset)), -600);
          chk("b_state_drop", int'(ifb.state), 2);
        end
        165: chk("t165_logo", int'($signed(ifa.logo_hoffset)), -600);
        166: chk("t166_head", int'($signed(ifa.head_voffset)), -160);
        182: begin
          chk("t182_head", int'($signed(ifa.head_voffset)), 0);
          chk("t182_done", int'(ifa.done), 1);
        end
        200: begin
          chk("t200_logo", int'($signed(ifa.logo_hoffset)), -600);
          chk("t200_state", int'(ifa.state), 3);
        end
        default: ;
      endcase
    end

    cnt = 0;
    first_i = -1;
    ifa.vsync = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ifa.frame_tick) begin
        cnt++;
        if (first_i < 0) first_i = i;
      end
    end
    ifa.vsync = 1'b0;
    repeat (4) begin @(negedge clk); cnt += int'(ifa.frame_tick); end
    ifa.vsync = 1'b1;
    @(negedge clk); cnt += int'(ifa.frame_tick);
    ifa.vsync = 1'b0;
    repeat (6) begin @(negedge clk); cnt += int'(ifa.frame_tick); end
    chk("wide_ticks", cnt, 2);
    chk("wide_latency", first_i, 3);

    restart_pulse();
    pulses(105);
    chk("pre_skip_logo", int'($signed(ifa.logo_hoffset)), -300);
    wait_tick("skip_tick_seen", found);
    if (found) begin
      ifa.skip = 1'b1;
      @(negedge clk);
      ifa.skip = 1'b0;
      chk("skip_logo",  int'($signed(ifa.logo_hoffset)), -600);
      chk("skip_head",  int'($signed(ifa.head_voffset)), 0);
      chk("skip_state", int'(ifa.state), 3);
      chk("skip_done",  int'(ifa.done), 1);
    end
    repeat (4) @(negedge clk);

    restart_pulse();
    pulses(170);
    chk("pre_rs_state", int'(ifa.state), 2);
    chk("pre_rs_head", int'($signed(ifa.head_voffset)), -120);
    wait_tick("rs_tick_seen", found);
    if (found) begin
      ifa.restart = 1'b1;
      @(negedge clk);
      ifa.restart = 1'b0;
      chk("rs_logo",  int'($signed(ifa.logo_hoffset)), 0);
      chk("rs_head",  int'($signed(ifa.head_voffset)), -170);
      chk("rs_state", int'(ifa.state), 0);
      chk("rs_done",  int'(ifa.done), 0);
    end
    repeat (4) @(negedge clk);
    pulses(44);
    chk("hold_44", int'(ifa.state), 0);
    pulses(1);
    chk("hold_45", int'(ifa.state), 1);

    pulses(50);
    chk("pre_rst_logo", int'($signed(ifa.logo_hoffset)), -250);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mrst_logo",  int'($signed(ifa.logo_hoffset)), 0);
    chk("mrst_head",  int'($signed(ifa.head_voffset)), -170);
    chk("mrst_state", int'(ifa.state), 0);
    chk("mrst_done",  int'(ifa.done), 0);
    @(negedge clk);
    cnt = 0;
    ifa.vsync = 1'b1;
    @(negedge clk); cnt += int'(ifa.frame_tick);
    ifa.vsync = 1'b0;
    repeat (8) begin @(negedge clk); cnt += int'(ifa.frame_tick); end
    chk("post_rst_ticks", cnt, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
